// File: rtl/pin_capt_sched_if.sv
// Event output bus of the pin capture scheduler: a valid/ready stream
// carrying channel index, timestamp and captured pin level.
interface pin_capt_sched_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(NCH)-1:0]   out_ch;
    logic [CNT_W+2:0]         out_ts;
    logic                     out_lvl;

    modport master (
        output out_valid,
        output out_ch,
        output out_ts,
        output out_lvl,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_ch,
        input  out_ts,
        input  out_lvl,
        output out_ready
    );
endinterface

// File: rtl/pin_capt_sched.sv
// Pin capture scheduler: timestamps strobes from NCH capture channels into
// one-deep per-channel slots and round-robins them onto one event stream.
module pin_capt_sched #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk300,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH-1:0]       str,
    input  logic [3*NCH-1:0]     ptime,
    input  logic [NCH-1:0]       pin_lvl,
    input  logic [NCH-1:0]       ovf_clr,
    output logic [NCH-1:0]       ovf,
    output logic [CNT_W-1:0]     coarse,
    pin_capt_sched_if.master     ev
);
    localparam int CH_W = $clog2(NCH);
    localparam int TS_W = CNT_W + 3;

    logic [CNT_W-1:0] coarse_q, coarse_d;
    logic [NCH-1:0]   slot_vld_q, slot_vld_d;
    logic [TS_W-1:0]  slot_ts_q [NCH];
    logic [TS_W-1:0]  slot_ts_d [NCH];
    logic [NCH-1:0]   slot_lvl_q, slot_lvl_d;
    logic [NCH-1:0]   ovf_q, ovf_d, ovf_set;
    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [TS_W-1:0]  out_ts_q, out_ts_d;
    logic             out_lvl_q, out_lvl_d;
    logic [CH_W-1:0]  last_grant_q, last_grant_d;

    logic             out_free;
    logic             gnt_found;
    logic [CH_W-1:0]  gnt_idx;

    // The output register can accept a new event when empty or being drained.
    assign out_free = !out_valid_q || ev.out_ready;

    // Round-robin search: first valid slot after the last granted one, with wrap.
    always_comb begin
        logic [CH_W:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = {1'b0, last_grant_q} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NCH)) begin
                cand = cand - (CH_W+1)'(NCH);
            end
            if (!gnt_found && slot_vld_q[cand[CH_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CH_W-1:0];
            end
        end
    end

    // Slot capture/release and sticky overflow; a slot being granted may reload.
    always_comb begin
        logic take;
        slot_vld_d = slot_vld_q;
        slot_ts_d  = slot_ts_q;
        slot_lvl_d = slot_lvl_q;
        ovf_set    = '0;
        take       = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            take = out_free && gnt_found && (gnt_idx == CH_W'(i));
            if (en && str[i]) begin
                if (!slot_vld_q[i] || take) begin
                    slot_vld_d[i] = 1'b1;
                    slot_ts_d[i]  = {coarse_q, ptime[3*i +: 3]};
                    slot_lvl_d[i] = pin_lvl[i];
                end else begin
                    ovf_set[i] = 1'b1;
                end
            end else if (take) begin
                slot_vld_d[i] = 1'b0;
            end
        end
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    // Output register load from the granted slot, plus the free-running counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_ch_d     = out_ch_q;
        out_ts_d     = out_ts_q;
        out_lvl_d    = out_lvl_q;
        last_grant_d = last_grant_q;
        coarse_d     = en ? coarse_q + CNT_W'(1) : coarse_q;
        if (out_free) begin
            if (gnt_found) begin
                out_valid_d  = 1'b1;
                out_ch_d     = gnt_idx;
                out_ts_d     = slot_ts_q[gnt_idx];
                out_lvl_d    = slot_lvl_q[gnt_idx];
                last_grant_d = gnt_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset leaves channel 0 with first priority.
    always_ff @(posedge clk300) begin
        if (!rst_n) begin
            coarse_q     <= '0;
            slot_vld_q   <= '0;
            slot_lvl_q   <= '0;
            ovf_q        <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_ts_q     <= '0;
            out_lvl_q    <= 1'b0;
            last_grant_q <= CH_W'(NCH-1);
            for (int i = 0; i < NCH; i++) begin
                slot_ts_q[i] <= '0;
            end
        end else begin
            coarse_q     <= coarse_d;
            slot_vld_q   <= slot_vld_d;
            slot_lvl_q   <= slot_lvl_d;
            ovf_q        <= ovf_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_ts_q     <= out_ts_d;
            out_lvl_q    <= out_lvl_d;
            last_grant_q <= last_grant_d;
            for (int i = 0; i < NCH; i++) begin
                slot_ts_q[i] <= slot_ts_d[i];
            end
        end
    end

    assign coarse       = coarse_q;
    assign ovf          = ovf_q;
    assign ev.out_valid = out_valid_q;
    assign ev.out_ch    = out_ch_q;
    assign ev.out_ts    = out_ts_q;
    assign ev.out_lvl   = out_lvl_q;
endmodule

// File: tb/tb_pin_capt_sched.sv
// Bench for pin_capt_sched: behavioural event model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pin_capt_sched;
    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int TS_W  = CNT_W + 3;

    logic                 clk300 = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [NCH-1:0]       str;
    logic [3*NCH-1:0]     ptime;
    logic [NCH-1:0]       pin_lvl;
    logic [NCH-1:0]       ovf_clr;
    logic [NCH-1:0]       ovf;
    logic [CNT_W-1:0]     coarse;

    pin_capt_sched_if #(.NCH(NCH), .CNT_W(CNT_W)) ev();

    pin_capt_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk300  (clk300),
        .rst_n   (rst_n),
        .en      (en),
        .str     (str),
        .ptime   (ptime),
        .pin_lvl (pin_lvl),
        .ovf_clr (ovf_clr),
        .ovf     (ovf),
        .coarse  (coarse),
        .ev      (ev)
    );

    always #5 clk300 = ~clk300;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel holds at most one pending event; the output holds one
    // presented event. Arbitration takes the first pending channel after the
    // previously granted one.
    bit              m_ov;
    int              m_ch;
    logic [TS_W-1:0] m_ts;
    bit              m_lvl;
    bit              m_pend [NCH];
    logic [TS_W-1:0] m_pts  [NCH];
    bit              m_plvl [NCH];
    bit [NCH-1:0]    m_ovf;
    int              m_last;
    int              m_coarse;

    always @(posedge clk300) begin : model
        bit free;
        int g;
        int c;
        if (!rst_n) begin
            m_ov = 0; m_ch = 0; m_ts = '0; m_lvl = 0;
            m_ovf = '0; m_last = NCH - 1; m_coarse = 0;
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 0; m_pts[i] = '0; m_plvl[i] = 0;
            end
        end else begin
            free = !m_ov || ev.out_ready;
            g = -1;
            if (free) begin
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_last + k) % NCH;
                    if (g < 0 && m_pend[c]) g = c;
                end
                if (g >= 0) begin
                    m_ov = 1; m_ch = g; m_ts = m_pts[g]; m_lvl = m_plvl[g];
                    m_pend[g] = 0; m_last = g;
                end else begin
                    m_ov = 0;
                end
            end
            m_ovf = m_ovf & ~ovf_clr;
            for (int i = 0; i < NCH; i++) begin
                if (en && str[i]) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1;
                        m_pts[i]  = {16'(m_coarse), ptime[3*i +: 3]};
                        m_plvl[i] = pin_lvl[i];
                    end else begin
                        m_ovf[i] = 1;
                    end
                end
            end
            if (en) m_coarse = (m_coarse + 1) % 65536;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk300) begin
        if (chk_en) begin
            chk("out_valid", 32'(ev.out_valid), 32'(m_ov));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("coarse", 32'(coarse), 32'(m_coarse));
            if (m_ov) begin
                chk("out_ch", 32'(ev.out_ch), 32'(m_ch));
                chk("out_ts", 32'(ev.out_ts), 32'(m_ts));
                chk("out_lvl", 32'(ev.out_lvl), 32'(m_lvl));
                if (ev.out_ready)
                    $display("xfer t=%0t ch=%0d coarse=%0d ptime=%0d lvl=%0d",
                             $time, ev.out_ch, ev.out_ts[TS_W-1:3], ev.out_ts[2:0], ev.out_lvl);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk300);
        #1;
    endtask

    task automatic pulse(input logic [NCH-1:0] s);
        str = s;
        tick();
        str = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int t1;
    int hold;

    initial begin
        rst_n = 1'b0; en = 1'b0; str = '0; ptime = '0; pin_lvl = '0;
        ovf_clr = '0; ev.out_ready = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_valid", 32'(ev.out_valid), 0);
        chk("rst_ts", 32'(ev.out_ts), 0);
        chk("rst_ch", 32'(ev.out_ch), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_coarse", 32'(coarse), 0);

        // single event: str[2] at coarse 5 appears in cycle 7 for one cycle
        rst_n = 1'b1; en = 1'b1; ev.out_ready = 1'b1;
        repeat (5) tick();
        chk("coarse5", 32'(coarse), 5);
        ptime = 12'(6) << 6; pin_lvl = 4'b0100;
        pulse(4'b0100);
        chk("single_c6_valid", 32'(ev.out_valid), 0);
        tick();
        chk("single_valid", 32'(ev.out_valid), 1);
        chk("single_ch", 32'(ev.out_ch), 2);
        chk("single_ts", 32'(ev.out_ts), (5 << 3) | 6);
        chk("single_lvl", 32'(ev.out_lvl), 1);
        tick();
        chk("single_end", 32'(ev.out_valid), 0);

        // round-robin from reset: two bursts both give 0,1,2,3
        do_reset();
        ptime = {3'd7, 3'd5, 3'd3, 3'd1}; pin_lvl = 4'b1010;
        pulse(4'b1111);
        tick();
        for (int k = 0; k < NCH; k++) begin
            chk("rr1_ch", 32'(ev.out_ch), 32'(k));
            tick();
        end
        chk("rr1_end", 32'(ev.out_valid), 0);
        pulse(4'b1111);
        tick();
        for (int k = 0; k < NCH; k++) begin
            chk("rr2_ch", 32'(ev.out_ch), 32'(k));
            tick();
        end

        // backpressure: ch0 occupies output, ch1 twice -> second dropped
        ev.out_ready = 1'b0;
        pulse(4'b0001);
        tick();
        t1 = m_coarse;
        pulse(4'b0010);
        tick(); tick();
        pulse(4'b0010);
        chk("bp_ovf", 32'(ovf), 32'(4'b0010));
        chk("bp_hold_ch", 32'(ev.out_ch), 0);
        ev.out_ready = 1'b1;
        tick();
        chk("bp_ch1", 32'(ev.out_ch), 1);
        chk("bp_ts1", 32'(ev.out_ts[TS_W-1:3]), 32'(t1));
        tick();
        chk("bp_once", 32'(ev.out_valid), 0);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        chk("ovf_clr", 32'(ovf), 0);
        // clear in the same cycle as a new overflow: set wins
        ev.out_ready = 1'b0;
        pulse(4'b0001);
        tick();
        pulse(4'b0010);
        str = 4'b0010; ovf_clr = 4'b0010;
        tick();
        str = '0; ovf_clr = '0;
        chk("ovf_set_wins", 32'(ovf), 32'(4'b0010));
        ev.out_ready = 1'b1;
        repeat (3) tick();
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;

        // same-cycle grant and reload on channel 0
        t1 = m_coarse;
        str = 4'b0001;
        tick(); tick();
        str = '0;
        chk("reload_ts0", 32'(ev.out_ts[TS_W-1:3]), 32'(t1));
        tick();
        chk("reload_ts1", 32'(ev.out_ts[TS_W-1:3]), 32'((t1 + 1) % 65536));
        chk("reload_ovf", 32'(ovf), 0);
        tick();

        // counter wrap
        for (int k = 0; k < 70000 && m_coarse != 65535; k++) tick();
        chk("pre_wrap", 32'(coarse), 65535);
        ptime[11:9] = 3'd1;
        pulse(4'b1000);
        ptime[11:9] = 3'd2;
        pulse(4'b1000);
        chk("wrap_ts_a", 32'(ev.out_ts), (65535 << 3) | 1);
        tick();
        chk("wrap_ts_b", 32'(ev.out_ts), 2);
        tick();

        // en=0 ignores strobes, holds coarse, pending slot still drains
        ev.out_ready = 1'b0;
        pulse(4'b0001);
        pulse(4'b0010);
        tick();
        en = 1'b0;
        hold = m_coarse;
        pulse(4'b0100);
        tick();
        chk("en0_coarse", 32'(coarse), 32'(hold));
        ev.out_ready = 1'b1;
        tick();
        chk("en0_drain_ch", 32'(ev.out_ch), 1);
        tick();
        chk("en0_no_ev", 32'(ev.out_valid), 0);
        en = 1'b1;

        // reset mid-operation
        ev.out_ready = 1'b0;
        pulse(4'b0111);
        tick();
        pulse(4'b0010);
        chk("mid_valid", 32'(ev.out_valid), 1);
        chk("mid_ovf", 32'(ovf), 32'(4'b0010));
        rst_n = 1'b0;
        tick();
        chk("mrst_valid", 32'(ev.out_valid), 0);
        chk("mrst_ovf", 32'(ovf), 0);
        chk("mrst_coarse", 32'(coarse), 0);
        rst_n = 1'b1; ev.out_ready = 1'b1;
        pulse(4'b1111);
        tick();
        chk("mrst_first_ch", 32'(ev.out_ch), 0);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pin_capt_sched.md
Name: pin_capt_sched

Overview:
- Collects strobe events from NCH pin_capt capture channels, all running in the clk300 domain.
- Timestamps each event as {coarse cycle counter, 3-bit fine phase ptime} and holds it in a one-deep slot per channel.
- A round-robin arbiter shares a single valid/ready event output between the channels.
- Sits between the pin_capt array and the downstream timestamp FIFO/readout logic.

Parameters:
- NCH, 4, number of pin_capt channels served (2..16).
- CNT_W, 16, width of the coarse clk300 cycle counter; the timestamp is CNT_W+3 bits.

Ports:
- clk300  input  1  system clock, 300 MHz; pin_capt str/ptime/pin_out are synchronous to it.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  capture enable; gates the counter and event acceptance.
- str  input  NCH  per-channel event strobe from pin_capt, one clk300 cycle wide.
- ptime  input  3*NCH  per-channel fine phase; channel i uses bits [3i+2:3i]. Valid only with str[i].
- pin_lvl  input  NCH  per-channel pin_out level, qualified by str[i].
- out_valid  output  1  event available.
- out_ready  input  1  consumer accepts the event when out_valid and out_ready are both 1.
- out_ch  output  $clog2(NCH)  channel index of the event.
- out_ts  output  CNT_W+3  timestamp, {coarse, ptime}.
- out_lvl  output  1  pin level captured with the event.
- ovf  output  NCH  sticky per-channel overflow flags (an event was dropped).
- ovf_clr  input  NCH  per-bit clear for ovf.
- coarse  output  CNT_W  current coarse counter value.

Behaviour:
- Reset (rst_n=0 at a clk300 edge) clears:
  - coarse, all slots, ovf, out_valid, out_ch, out_ts, out_lvl to 0;
  - last_grant to NCH-1, so channel 0 has first priority.
- Reset mid-operation discards pending and presented events without raising overflow.
- Coarse counter:
  - increments by 1 each cycle while en=1 and holds while en=0;
  - wraps from 2^CNT_W-1 to 0 with no flag.
- Event capture:
  - str[i]=1 with en=1 in cycle n loads slot i with {coarse(n), ptime_i, pin_lvl[i]}.
  - Slot i is then valid from cycle n+1.
- Slot occupancy on a new str[i]:
  - Slot empty: load the new event.
  - Slot full and being granted in the same cycle: load the new event, no overflow.
  - Slot full and not granted: keep the old event, drop the new one, set ovf[i].
- ovf behaviour:
  - ovf[i] holds until ovf_clr[i]=1.
  - If set and clear occur in the same cycle, set wins.
- en=0:
  - str is ignored.
  - Slots already full and the output register keep draining normally.
- Output register:
  - Loads when it is free, meaning out_valid=0 or (out_valid=1 and out_ready=1) in that cycle.
  - Back-to-back throughput is one event per cycle.
- Arbitration, evaluated in each cycle the output register is free:
  - Search valid slots starting at (last_grant+1) mod NCH, ascending with wrap.
  - The first valid slot j is granted; slot j clears, the output loads slot j, and last_grant becomes j.
  - If no slot is valid, out_valid goes 0 when the current event is taken; otherwise it holds.
- Minimum latency: str in cycle n gives out_valid=1 in cycle n+2.
- Output hold rule: while out_valid=1 and out_ready=0, out_ch, out_ts and out_lvl stay stable.
- Starvation bound: with all channels continuously pending, each channel is granted at least once every NCH accepted transfers.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Single event: reset, en=1; after 5 cycles (coarse=5) pulse str[2] with ptime=3'd6, pin_lvl=1, out_ready=1.
  - Expected: out_valid in cycle 7 with out_ch=2, out_ts={16'd5,3'd6}, out_lvl=1, for exactly 1 cycle.
- Round-robin: str=4'b1111 in one cycle, out_ready=1.
  - Expected: out_ch sequence 0,1,2,3 on consecutive cycles; a second burst gives 0,1,2,3 again (last_grant=3 wraps to 0).
- Backpressure/overflow: out_ready=0; pulse str[1] twice, 3 cycles apart.
  - Expected: ovf=4'b0010; the first event is retained.
  - Then out_ready=1: exactly one event for channel 1, with the first timestamp.
  - ovf_clr[1]=1 clears it; clear in the same cycle as a new overflow leaves ovf[1]=1.
- Same-cycle grant and reload: out_ready=1; str[0] on consecutive cycles.
  - Expected: two events with timestamps differing by 1; ovf stays 0.
- Wrap and enable: preload coarse near 2^16-1 by running; events straddling the wrap.
  - Expected: out_ts coarse goes 65535 then 0.
  - en=0 with str pulses: no events and coarse holds; a pending slot still drains.
- Reset mid-operation: rst_n=0 with out_valid=1, two slots full and ovf set.
  - Expected next cycle: out_valid=0, ovf=0, coarse=0.
  - First post-reset burst is granted channel 0 first.
